writeback_arbiter: RTL and testbench

WRITEBACK_ARBITER -- requirements
Module: writeback_arbiter

---
 rtl/writeback_arbiter_pkg.sv | 13 +
 rtl/writeback_arbiter_fifo.sv | 62 ++++++
 rtl/writeback_arbiter.sv | 126 ++++++++++++
 tb/tb_writeback_arbiter.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/writeback_arbiter_pkg.sv
// Shared core types for the writeback path: register address width, data width
// and the buffered result entry.
package writeback_arbiter_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int XLEN       = 32;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [XLEN-1:0]       data;
    } wb_entry_t;

endpackage

// File: rtl/writeback_arbiter_fifo.sv
// wb_fifo: small in-order buffer for ALU results that lost the commit slot.
// Exposes per-slot destination tags so the hazard logic can see buffered writes.
module wb_fifo
    import writeback_arbiter_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        push,
    input  wb_entry_t                   push_entry,
    input  logic                        pop,
    output wb_entry_t                   head,
    output logic [2:0]                  count,
    output logic [DEPTH-1:0]            slot_valid,
    output logic [DEPTH*REG_ADDR_W-1:0] slot_rd
);

    localparam int PTR_W = $clog2(DEPTH);

    wb_entry_t        buf_mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [2:0]       count_reg;

    // Storage carries no reset: a slot is only observed once its valid bit is set.
    always_ff @(posedge clk) begin
        if (push) begin
            buf_mem[wr_ptr_reg] <= push_entry;
        end
    end

    // Power-of-two depth, so pointer overflow is the modulo wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            count_reg <= count_reg + {2'b00, push} - {2'b00, pop};
        end
    end

    assign head  = buf_mem[rd_ptr_reg];
    assign count = count_reg;

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
            logic [PTR_W-1:0] offset;
            assign offset = PTR_W'(gi) - rd_ptr_reg;
            assign slot_valid[gi] = 3'(offset) < count_reg;
            assign slot_rd[gi*REG_ADDR_W +: REG_ADDR_W] = buf_mem[gi].rd;
        end
    endgenerate

endmodule

// File: rtl/writeback_arbiter.sv
// Writeback arbiter: merges load responses and ALU results into one register
// file write port, with a pending-load scoreboard for hazard detection.
module writeback_arbiter
    import writeback_arbiter_pkg::*;
#(
    parameter int ALU_FIFO_DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  alu_valid,
    output logic                  alu_ready,
    input  logic [REG_ADDR_W-1:0] alu_rd,
    input  logic [XLEN-1:0]       alu_data,
    input  logic                  mem_valid,
    output logic                  mem_ready,
    input  logic [REG_ADDR_W-1:0] mem_rd,
    input  logic [XLEN-1:0]       mem_data,
    input  logic                  load_issue,
    input  logic [REG_ADDR_W-1:0] load_issue_rd,
    input  logic [REG_ADDR_W-1:0] rs1_addr,
    input  logic [REG_ADDR_W-1:0] rs2_addr,
    output logic                  rs_hazard,
    output logic                  write_enable,
    output logic [REG_ADDR_W-1:0] address3,
    output logic [XLEN-1:0]       write_data,
    output logic [2:0]            alu_fifo_count
);

    logic                  alu_fire;
    logic                  fifo_push;
    logic                  fifo_pop;
    logic                  commit_valid;
    wb_entry_t             commit_entry;
    wb_entry_t             fifo_head;
    logic [ALU_FIFO_DEPTH-1:0]            slot_valid;
    logic [ALU_FIFO_DEPTH*REG_ADDR_W-1:0] slot_rd;
    logic [ALU_FIFO_DEPTH-1:0]            buf_hit;

    logic [31:0]           pending_reg;
    logic [31:0]           pending_next;
    logic                  write_enable_reg;
    logic [REG_ADDR_W-1:0] address3_reg;
    logic [XLEN-1:0]       write_data_reg;

    // Full blocks acceptance even when the head drains this cycle.
    assign alu_ready = alu_fifo_count < 3'(ALU_FIFO_DEPTH);
    assign mem_ready = 1'b1;
    assign alu_fire  = alu_valid && alu_ready;

    always_comb begin
        commit_valid = 1'b0;
        commit_entry = '0;
        fifo_push    = 1'b0;
        fifo_pop     = 1'b0;
        if (mem_valid) begin
            commit_valid = 1'b1;
            commit_entry = '{rd: mem_rd, data: mem_data};
            fifo_push    = alu_fire;
        end else if (alu_fifo_count != 3'd0) begin
            commit_valid = 1'b1;
            commit_entry = fifo_head;
            fifo_pop     = 1'b1;
            fifo_push    = alu_fire;
        end else if (alu_fire) begin
            commit_valid = 1'b1;
            commit_entry = '{rd: alu_rd, data: alu_data};
        end
    end

    wb_fifo #(.DEPTH(ALU_FIFO_DEPTH)) u_alu_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (fifo_push),
        .push_entry ('{rd: alu_rd, data: alu_data}),
        .pop        (fifo_pop),
        .head       (fifo_head),
        .count      (alu_fifo_count),
        .slot_valid (slot_valid),
        .slot_rd    (slot_rd)
    );

    // Clear first so a same-cycle issue to the same rd keeps the bit set.
    always_comb begin
        pending_next = pending_reg;
        if (mem_valid) begin
            pending_next[mem_rd] = 1'b0;
        end
        if (load_issue && load_issue_rd != '0) begin
            pending_next[load_issue_rd] = 1'b1;
        end
        pending_next[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_reg      <= '0;
            write_enable_reg <= 1'b0;
            address3_reg     <= '0;
            write_data_reg   <= '0;
        end else begin
            pending_reg      <= pending_next;
            write_enable_reg <= commit_valid && commit_entry.rd != '0;
            if (commit_valid && commit_entry.rd != '0) begin
                address3_reg   <= commit_entry.rd;
                write_data_reg <= commit_entry.data;
            end
        end
    end

    assign write_enable = write_enable_reg;
    assign address3     = address3_reg;
    assign write_data   = write_data_reg;

    generate
        for (genvar gi = 0; gi < ALU_FIFO_DEPTH; gi++) begin : g_hit
            logic [REG_ADDR_W-1:0] rd_tag;
            assign rd_tag      = slot_rd[gi*REG_ADDR_W +: REG_ADDR_W];
            assign buf_hit[gi] = slot_valid[gi] && rd_tag != '0 &&
                                 (rd_tag == rs1_addr || rd_tag == rs2_addr);
        end
    endgenerate

    assign rs_hazard = pending_reg[rs1_addr] || pending_reg[rs2_addr] || (|buf_hit) ||
                       (write_enable_reg && (address3_reg == rs1_addr || address3_reg == rs2_addr));

endmodule

// File: tb/tb_writeback_arbiter.sv
// Randomized and directed bench for writeback_arbiter against a queue-based
// reference model of the commit, buffering and scoreboard rules.
module tb_writeback_arbiter;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        alu_valid, alu_ready, mem_valid, mem_ready, load_issue;
    logic [4:0]  alu_rd, mem_rd, load_issue_rd, rs1_addr, rs2_addr, address3;
    logic [31:0] alu_data, mem_data, write_data;
    logic        rs_hazard, write_enable;
    logic [2:0]  alu_fifo_count;

    always #5 clk = ~clk;

    writeback_arbiter #(.ALU_FIFO_DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .alu_valid      (alu_valid),
        .alu_ready      (alu_ready),
        .alu_rd         (alu_rd),
        .alu_data       (alu_data),
        .mem_valid      (mem_valid),
        .mem_ready      (mem_ready),
        .mem_rd         (mem_rd),
        .mem_data       (mem_data),
        .load_issue     (load_issue),
        .load_issue_rd  (load_issue_rd),
        .rs1_addr       (rs1_addr),
        .rs2_addr       (rs2_addr),
        .rs_hazard      (rs_hazard),
        .write_enable   (write_enable),
        .address3       (address3),
        .write_data     (write_data),
        .alu_fifo_count (alu_fifo_count)
    );

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } ent_t;

    // Reference model state
    ent_t        q[$];
    bit [31:0]   pend;
    bit          m_we;
    logic [4:0]  m_addr;
    logic [31:0] m_data;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic bit haz(input logic [4:0] rs);
        if (rs == 5'd0) return 1'b0;
        if (pend[rs]) return 1'b1;
        if (m_we && m_addr == rs) return 1'b1;
        foreach (q[i]) if (q[i].rd == rs) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_reset();
        q.delete();
        pend   = '0;
        m_we   = 1'b0;
        m_addr = '0;
        m_data = '0;
    endtask

    task automatic idle();
        alu_valid = 0; alu_rd = 0; alu_data = 0;
        mem_valid = 0; mem_rd = 0; mem_data = 0;
        load_issue = 0; load_issue_rd = 0;
    endtask

    // Called just after a falling edge with inputs applied; checks, advances the model, clocks once.
    task automatic step();
        bit   acc;
        bit   has;
        ent_t c;
        #1;
        chk("alu_ready", alu_ready, 32'(q.size() < DEPTH));
        chk("mem_ready", mem_ready, 1);
        chk("count", alu_fifo_count, q.size());
        chk("write_enable", write_enable, m_we);
        chk("address3", address3, m_addr);
        chk("write_data", write_data, m_data);
        chk("rs_hazard", rs_hazard, haz(rs1_addr) || haz(rs2_addr));

        acc = alu_valid && q.size() < DEPTH;
        has = 1'b0;
        c   = '{rd: 5'd0, data: 32'd0};
        if (mem_valid) begin
            c = '{rd: mem_rd, data: mem_data};
            has = 1'b1;
            if (acc) q.push_back('{rd: alu_rd, data: alu_data});
        end else if (q.size() > 0) begin
            c = q.pop_front();
            has = 1'b1;
            if (acc) q.push_back('{rd: alu_rd, data: alu_data});
        end else if (acc) begin
            c = '{rd: alu_rd, data: alu_data};
            has = 1'b1;
        end
        m_we = has && c.rd != 5'd0;
        if (m_we) begin
            m_addr = c.rd;
            m_data = c.data;
        end
        if (mem_valid) pend[mem_rd] = 1'b0;
        if (load_issue && load_issue_rd != 5'd0) pend[load_issue_rd] = 1'b1;

        $display("cyc=%0d alu=%b/%0d/%h acc=%b mem=%b/%0d/%h li=%b/%0d rs=%0d,%0d -> exp_we=%b a3=%0d wd=%h q=%0d",
                 cyc, alu_valid, alu_rd, alu_data, acc, mem_valid, mem_rd, mem_data,
                 load_issue, load_issue_rd, rs1_addr, rs2_addr, m_we, m_addr, m_data, q.size());
        cyc++;
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        rs1_addr = 0;
        rs2_addr = 0;
        model_reset();
        repeat (2) @(negedge clk);
        #1;
        chk("reset_we", write_enable, 0);
        chk("reset_count", alu_fifo_count, 0);
        chk("reset_alu_ready", alu_ready, 1);
        chk("reset_hazard", rs_hazard, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Lone ALU write
        alu_valid = 1; alu_rd = 5; alu_data = 32'hDEADBEEF;
        step();
        idle();
        step();
        chk("lone_addr", address3, 5);
        chk("lone_data", write_data, 32'hDEADBEEF);

        // Collision: mem wins, ALU buffered then drained
        alu_valid = 1; alu_rd = 3; alu_data = 32'h11;
        mem_valid = 1; mem_rd = 4; mem_data = 32'h22;
        step();
        idle();
        repeat (3) step();

        // Back-pressure: mem held three cycles, ALU continuous
        for (int i = 0; i < 8; i++) begin
            alu_valid = 1; alu_rd = 5'(10 + i); alu_data = 32'hA000 + 32'(i);
            mem_valid = (i < 3); mem_rd = 5'(20 + i); mem_data = 32'hB000 + 32'(i);
            step();
        end
        idle();
        repeat (3) step();

        // Scoreboard: load to r7, hazard until the cycle after its mem commit
        rs1_addr = 7;
        load_issue = 1; load_issue_rd = 7;
        step();
        idle();
        repeat (3) step();
        mem_valid = 1; mem_rd = 7; mem_data = 32'h77;
        step();
        idle();
        repeat (2) step();
        load_issue = 1; load_issue_rd = 0; rs1_addr = 0; rs2_addr = 0;
        step();
        idle();
        repeat (2) step();
        // Same-cycle set and clear of the same rd: set wins
        rs2_addr = 9;
        load_issue = 1; load_issue_rd = 9; mem_valid = 1; mem_rd = 9; mem_data = 32'h99;
        step();
        idle();
        repeat (2) step();

        // x0 suppression
        alu_valid = 1; alu_rd = 0; alu_data = 32'hFFFFFFFF;
        step();
        idle();
        repeat (2) step();

        // Reset mid-operation with two entries buffered and a pending load
        rs1_addr = 12;
        load_issue = 1; load_issue_rd = 12;
        alu_valid = 1; alu_rd = 13; alu_data = 32'h1313;
        mem_valid = 1; mem_rd = 14; mem_data = 32'h1414;
        step();
        alu_rd = 15; alu_data = 32'h1515; mem_rd = 16; mem_data = 32'h1616; load_issue = 0;
        step();
        idle();
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_we", write_enable, 0);
        chk("midrst_count", alu_fifo_count, 0);
        chk("midrst_hazard", rs_hazard, 0);
        chk("midrst_alu_ready", alu_ready, 1);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) step();

        // Randomized traffic
        for (int i = 0; i < 500; i++) begin
            alu_valid     = ($urandom_range(0, 9) < 6);
            alu_rd        = 5'($urandom_range(0, 7));
            alu_data      = $urandom;
            mem_valid     = ($urandom_range(0, 9) < 3);
            mem_rd        = 5'($urandom_range(0, 7));
            mem_data      = $urandom;
            load_issue    = ($urandom_range(0, 9) < 2);
            load_issue_rd = 5'($urandom_range(0, 7));
            rs1_addr      = 5'($urandom_range(0, 7));
            rs2_addr      = 5'($urandom_range(0, 31));
            step();
        end
        idle();
        repeat (4) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
